// File: rtl/washer_pkg.sv
// Shared definitions for the washing machine payment path.
// Contents:
//   acceptor_state_t - coin acceptor state encoding
//   COIN_*           - credit units of each coin denomination
//   coin_units()     - maps a 2-bit coin_value code to its credit units
package washer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_BUSY    = 2'd3
  } acceptor_state_t;

  localparam logic [3:0] COIN_1  = 4'd1;
  localparam logic [3:0] COIN_2  = 4'd2;
  localparam logic [3:0] COIN_5  = 4'd5;
  localparam logic [3:0] COIN_10 = 4'd10;

  function automatic logic [3:0] coin_units(input logic [1:0] code);
    logic [3:0] units;
    units = COIN_1;
    case (code)
      2'b00: units = COIN_1;
      2'b01: units = COIN_2;
      2'b10: units = COIN_5;
      2'b11: units = COIN_10;
      default: units = COIN_1;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// Signal bundle between the coin mechanism / controller side and the coin
// acceptor.
// Signals:
//   coin_valid, coin_value - coin strobe and its denomination code
//   cancel                 - user abort request
//   wash_done              - controller status level, rising edge ends a wash
//   coin_in                - vend pulse to the controller
//   credit                 - accumulated credit
//   refund_valid/amount    - change / refund dispense strobe and amount
//   busy                   - a paid wash is in progress
// Modports: master drives the requests, slave is the acceptor itself.
interface coin_acceptor_if #(
  parameter int CREDIT_W = 8
);
  logic                coin_valid;
  logic [1:0]          coin_value;
  logic                cancel;
  logic                wash_done;
  logic                coin_in;
  logic [CREDIT_W-1:0] credit;
  logic                refund_valid;
  logic [CREDIT_W-1:0] refund_amount;
  logic                busy;

  modport master (
    output coin_valid, coin_value, cancel, wash_done,
    input  coin_in, credit, refund_valid, refund_amount, busy
  );

  modport slave (
    input  coin_valid, coin_value, cancel, wash_done,
    output coin_in, credit, refund_valid, refund_amount, busy
  );
endinterface

// File: rtl/rise_detect.sv
// Registered rising-edge detector for a controller status level.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   level      - monitored level
//   rise       - high while level is 1 and its registered previous value is 0
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= level;
  end

  // The history resets to 0 so a level already high out of reset reads as an edge.
  assign rise = level & ~prev;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: accumulates coin credit, issues one coin_in pulse when the
// wash price is reached, returns change, rejects coins while a wash is paid
// for, and waits for a fresh wash_done rising edge before accepting again.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   bus        - coin_acceptor_if slave modport (all outputs registered)
// Parameters:
//   PRICE    - wash price in credit units (PRICE + 10 < 2**CREDIT_W)
//   CREDIT_W - width of credit and refund values
module coin_acceptor
  import washer_pkg::*;
#(
  parameter int PRICE    = 20,
  parameter int CREDIT_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  coin_acceptor_if.slave   bus
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  acceptor_state_t     state_q, state_n;
  logic [CREDIT_W-1:0] credit_q, credit_n;
  logic                coin_in_q, coin_in_n;
  logic                busy_q, busy_n;
  logic                refund_valid_q, refund_valid_n;
  logic [CREDIT_W-1:0] refund_amount_q, refund_amount_n;
  logic                pend_valid_q, pend_valid_n;
  logic [CREDIT_W-1:0] pend_amount_q, pend_amount_n;

  logic [CREDIT_W-1:0] coin_amt;
  logic [CREDIT_W-1:0] sum;
  logic                src_valid;
  logic [CREDIT_W-1:0] src_amount;
  logic                wash_rise;

  rise_detect u_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .level (bus.wash_done),
    .rise  (wash_rise)
  );

  assign coin_amt = CREDIT_W'(coin_units(bus.coin_value));
  assign sum      = credit_q + coin_amt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      credit_q        <= '0;
      coin_in_q       <= 1'b0;
      busy_q          <= 1'b0;
      refund_valid_q  <= 1'b0;
      refund_amount_q <= '0;
      pend_valid_q    <= 1'b0;
      pend_amount_q   <= '0;
    end else begin
      state_q         <= state_n;
      credit_q        <= credit_n;
      coin_in_q       <= coin_in_n;
      busy_q          <= busy_n;
      refund_valid_q  <= refund_valid_n;
      refund_amount_q <= refund_amount_n;
      pend_valid_q    <= pend_valid_n;
      pend_amount_q   <= pend_amount_n;
    end
  end

  // src_* is this cycle's refund request (change, cancel refund or rejected coin);
  // the states make these sources mutually exclusive.
  always_comb begin
    state_n    = state_q;
    credit_n   = credit_q;
    coin_in_n  = 1'b0;
    src_valid  = 1'b0;
    src_amount = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.coin_valid) begin
          credit_n = coin_amt;
          if (coin_amt >= PRICE_C) begin
            state_n    = ST_VEND;
            coin_in_n  = 1'b1;
            src_valid  = (coin_amt != PRICE_C);
            src_amount = coin_amt - PRICE_C;
          end else begin
            state_n = ST_COLLECT;
          end
        end
      end
      ST_COLLECT: begin
        // Cancel takes priority even if the coin in the same cycle would pay.
        if (bus.cancel) begin
          state_n    = ST_IDLE;
          credit_n   = '0;
          src_valid  = 1'b1;
          src_amount = bus.coin_valid ? sum : credit_q;
        end else if (bus.coin_valid) begin
          if (sum >= PRICE_C) begin
            state_n    = ST_VEND;
            coin_in_n  = 1'b1;
            src_valid  = (sum != PRICE_C);
            src_amount = sum - PRICE_C;
          end else begin
            credit_n = sum;
          end
        end
      end
      ST_VEND: begin
        state_n    = ST_BUSY;
        credit_n   = '0;
        src_valid  = bus.coin_valid;
        src_amount = bus.coin_valid ? coin_amt : '0;
      end
      ST_BUSY: begin
        credit_n   = '0;
        src_valid  = bus.coin_valid;
        src_amount = bus.coin_valid ? coin_amt : '0;
        if (wash_rise) state_n = ST_IDLE;
      end
      default: begin
        state_n  = ST_IDLE;
        credit_n = '0;
      end
    endcase
  end

  // One refund per cycle: an older pending refund goes out first and the new
  // request waits in the single pending slot.
  always_comb begin
    refund_valid_n  = 1'b0;
    refund_amount_n = '0;
    pend_valid_n    = pend_valid_q;
    pend_amount_n   = pend_amount_q;
    if (pend_valid_q) begin
      refund_valid_n  = 1'b1;
      refund_amount_n = pend_amount_q;
      pend_valid_n    = src_valid;
      pend_amount_n   = src_valid ? src_amount : '0;
    end else if (src_valid) begin
      refund_valid_n  = 1'b1;
      refund_amount_n = src_amount;
    end
  end

  assign busy_n = (state_n == ST_BUSY);

  assign bus.coin_in       = coin_in_q;
  assign bus.credit        = credit_q;
  assign bus.busy          = busy_q;
  assign bus.refund_valid  = refund_valid_q;
  assign bus.refund_amount = refund_amount_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed scenarios followed by
// random coin/cancel/wash_done traffic, compared every cycle against a
// behavioural model built on a credit counter and a refund queue.
module tb_coin_acceptor;

  localparam int PRICE    = 20;
  localparam int CREDIT_W = 8;

  logic clk;
  logic rst_n;

  coin_acceptor_if #(.CREDIT_W(CREDIT_W)) bus ();

  coin_acceptor #(.PRICE(PRICE), .CREDIT_W(CREDIT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Behavioural model state
  int  m_credit;
  bit  m_vend_cycle;
  bit  m_washing;
  bit  m_wd_prev;
  int  m_refq[$];
  int  e_coin_in;
  int  e_credit;
  int  e_refund_valid;
  int  e_refund_amount;
  int  e_busy;
  int  denom[4] = '{1, 2, 5, 10};

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, actual, expected);
    end
  endtask

  function automatic void modelReset();
    m_credit     = 0;
    m_vend_cycle = 0;
    m_washing    = 0;
    m_wd_prev    = 0;
    m_refq.delete();
    e_coin_in       = 0;
    e_credit        = 0;
    e_refund_valid  = 0;
    e_refund_amount = 0;
    e_busy          = 0;
  endfunction

  // Advances the model by one clock edge with the given inputs.
  function automatic void modelStep(input bit cv, input bit [1:0] code, input bit c, input bit wd);
    int units;
    int total;
    bit rise;
    units     = denom[code];
    rise      = wd && !m_wd_prev;
    m_wd_prev = wd;
    e_coin_in = 0;
    if (m_vend_cycle) begin
      if (cv) m_refq.push_back(units);
      m_credit     = 0;
      m_vend_cycle = 0;
      m_washing    = 1;
    end else if (m_washing) begin
      if (cv) m_refq.push_back(units);
      if (rise) m_washing = 0;
    end else if (c && m_credit > 0) begin
      m_refq.push_back(m_credit + (cv ? units : 0));
      m_credit = 0;
    end else if (cv) begin
      total = m_credit + units;
      if (total >= PRICE) begin
        e_coin_in    = 1;
        m_vend_cycle = 1;
        if (total > PRICE) m_refq.push_back(total - PRICE);
      end else begin
        m_credit = total;
      end
    end
    e_credit = m_credit;
    e_busy   = m_washing;
    if (m_refq.size() > 0) begin
      e_refund_valid  = 1;
      e_refund_amount = m_refq.pop_front();
    end else begin
      e_refund_valid  = 0;
      e_refund_amount = 0;
    end
  endfunction

  task automatic checkAll();
    checkOutput("coin_in",       int'(bus.coin_in),       e_coin_in);
    checkOutput("credit",        int'(bus.credit),        e_credit);
    checkOutput("refund_valid",  int'(bus.refund_valid),  e_refund_valid);
    checkOutput("refund_amount", int'(bus.refund_amount), e_refund_amount);
    checkOutput("busy",          int'(bus.busy),          e_busy);
  endtask

  // Drives one cycle of inputs (called just after a falling edge), steps the
  // model at the rising edge and compares shortly after it.
  task automatic applyStimulus(input bit cv, input bit [1:0] code, input bit c, input bit wd);
    bus.coin_valid = cv;
    bus.coin_value = code;
    bus.cancel     = c;
    bus.wash_done  = wd;
    @(posedge clk);
    modelStep(cv, code, c, wd);
    #1;
    checkAll();
    @(negedge clk);
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idleCycles(input int n, input bit wd);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, 1'b0, wd);
  endtask

  bit       r_cv;
  bit [1:0] r_code;
  bit       r_cancel;
  bit       r_wd;

  initial begin
    checks = 0;
    errors = 0;
    bus.coin_valid = 1'b0;
    bus.coin_value = 2'b00;
    bus.cancel     = 1'b0;
    bus.wash_done  = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    applyReset();

    $display("[TB] coins 10, 5, 5 reach the price exactly");
    applyStimulus(1, 2'b11, 0, 0);
    applyStimulus(1, 2'b10, 0, 0);
    applyStimulus(1, 2'b10, 0, 0);
    idleCycles(2, 0);
    applyStimulus(0, 2'b00, 0, 1);
    idleCycles(2, 1);

    $display("[TB] coins 10, 10, 5 with the 5 rejected");
    applyStimulus(1, 2'b11, 0, 1);
    applyStimulus(1, 2'b11, 0, 1);
    applyStimulus(1, 2'b10, 0, 1);
    idleCycles(2, 1);
    applyStimulus(0, 2'b00, 0, 0);
    applyStimulus(1, 2'b01, 0, 0);
    applyStimulus(0, 2'b00, 0, 1);
    idleCycles(2, 0);

    $display("[TB] coins 10, 5, 10 return change");
    applyStimulus(1, 2'b11, 0, 0);
    applyStimulus(1, 2'b10, 0, 0);
    applyStimulus(1, 2'b11, 0, 0);
    idleCycles(2, 0);
    applyStimulus(0, 2'b00, 1, 1);
    idleCycles(2, 0);

    $display("[TB] cancel together with a coin");
    applyStimulus(1, 2'b10, 0, 0);
    applyStimulus(1, 2'b01, 0, 0);
    applyStimulus(1, 2'b00, 1, 0);
    idleCycles(2, 0);
    applyStimulus(0, 2'b00, 1, 0);

    $display("[TB] cancel wins over reaching the price");
    applyStimulus(1, 2'b11, 0, 0);
    applyStimulus(1, 2'b11, 1, 0);
    idleCycles(1, 0);

    $display("[TB] wash_done held high needs a fresh edge");
    idleCycles(2, 1);
    applyStimulus(1, 2'b11, 0, 1);
    applyStimulus(1, 2'b11, 0, 1);
    idleCycles(4, 1);
    idleCycles(2, 0);
    idleCycles(3, 1);

    $display("[TB] reset mid-collection discards credit");
    applyStimulus(1, 2'b11, 0, 0);
    applyStimulus(1, 2'b10, 0, 0);
    applyReset();
    idleCycles(1, 0);
    applyStimulus(1, 2'b11, 0, 0);
    idleCycles(2, 0);
    applyStimulus(0, 2'b00, 1, 0);

    $display("[TB] random traffic");
    r_wd = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      r_cv     = ($urandom_range(0, 2) == 0);
      r_code   = 2'($urandom_range(0, 3));
      r_cancel = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) r_wd = ~r_wd;
      applyStimulus(r_cv, r_code, r_cancel, r_wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Payment front-end for the washing machine controller. Accumulates coin credit, issues a single-cycle `coin_in` pulse to the controller once the wash price is reached, and returns change. Holds off further vends until the controller reports `wash_done`. Sits directly upstream of the controller, on the same clock and reset.

## Interface
Parameters:
- `PRICE`, 20: wash price in credit units; must satisfy `PRICE + 10 < 2**CREDIT_W`.
- `CREDIT_W`, 8: width of credit and refund values.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `coin_valid`  in  1  one-cycle strobe: a coin was inserted.
- `coin_value`  in  2  denomination, valid with `coin_valid`: 00=1, 01=2, 10=5, 11=10 units.
- `cancel`  in  1  one-cycle user request to abort and refund.
- `wash_done`  in  1  level from the controller; a rising edge ends the busy period.
- `coin_in`  out  1  one-cycle vend pulse to the controller.
- `credit`  out  CREDIT_W  current accumulated credit.
- `refund_valid`  out  1  one-cycle strobe: dispense `refund_amount`.
- `refund_amount`  out  CREDIT_W  amount to dispense; 0 when `refund_valid`=0.
- `busy`  out  1  high while a paid wash is in progress.

## Operation
- States: IDLE, COLLECT, VEND, BUSY.
- IDLE: `credit`=0. On `coin_valid`: credit ← value, go to COLLECT, or to VEND if value ≥ PRICE. `cancel` is ignored.
- COLLECT: on `coin_valid`, sum = credit + value.
  - sum ≥ PRICE: go to VEND, excess = sum − PRICE.
  - Otherwise: credit ← sum.
- COLLECT + `cancel`: refund credit (plus the coin if `coin_valid` is high in the same cycle), credit ← 0, go to IDLE. Cancel wins over reaching PRICE.
- VEND, one cycle:
  - `coin_in`=1.
  - If excess > 0: `refund_valid`=1, `refund_amount`=excess.
  - credit ← 0, next state BUSY.
- BUSY: `busy`=1. A rising edge of `wash_done` (registered previous value 0, current value 1) returns to IDLE.
  - Any `coin_valid` in BUSY is rejected: the next cycle has `refund_valid`=1 and `refund_amount`=that coin's value. Credit stays 0.
  - `cancel` in BUSY is ignored.
- Arithmetic is unsigned, CREDIT_W bits. The sum cannot overflow, given the parameter constraint.
- A coin arriving in VEND is handled as in BUSY: rejected and refunded in the next cycle. If this collides with the VEND change, the rejected coin's refund is issued one cycle later; a one-entry pending-refund register is sufficient.

## Timing
- All outputs are registered. Reset values: `coin_in`=0, `credit`=0, `refund_valid`=0, `refund_amount`=0, `busy`=0. State is IDLE. The `wash_done` history register resets to 0.
- Latency from the `coin_valid` that reaches PRICE to `coin_in`: 1 cycle. Change is issued in the same cycle as `coin_in`.
- `credit` reflects a coin 1 cycle after its strobe.
- Cancel refund appears 1 cycle after `cancel`.
- `busy` rises in the cycle after `coin_in` and falls 1 cycle after the `wash_done` rising edge is sampled.
- `wash_done` already high on entry to BUSY does not count; a fresh 0→1 transition is required.
- Reset mid-operation: credit is discarded and no refund is issued; all outputs take their reset values immediately.

## Structure
- Shared package `washer_pkg` holds:
  - the acceptor state encoding;
  - the coin denomination constants (1/2/5/10) and a decode function from `coin_value` to units.
- One natural sub-module: `rise_detect` (registered rising-edge detector on `wash_done`), reusable for other controller status lines.

## Test plan
- Reset, then coins 10, 5, 5 on separate cycles → `credit` reads 10, then 15; `coin_in` pulses 1 cycle after the third coin; no refund; `busy`=1 the next cycle.
- Coins 10, 10, 5 with PRICE=20 → after the second 10, `coin_in`=1 with no refund. The 5 arrives in BUSY and is refunded one cycle later with `refund_amount`=5.
- Coins 10, 5, 10 → `coin_in` pulses with `refund_valid`=1 and `refund_amount`=5 in the same cycle.
- Coins 5, 2, then `cancel` together with a 1 coin → `refund_amount`=8 one cycle later; state returns to IDLE; `credit`=0; no `coin_in`.
- Vend, hold `wash_done`=1 from the previous wash, then drop it to 0 and raise it again → `busy` stays 1 until the 0→1 edge and clears 1 cycle after it.
- Assert `rst_n`=0 with credit 15 in COLLECT → `credit`=0, no refund, no `coin_in`; a subsequent single 10 coin does not vend.
